// File: rtl/a2d_intf_if.sv
// Bundles the conversion handshake with the motion controller and the SPI pins of the
// off-chip A2D converter.
// master: the a2d_intf side, which drives SPI and reports results.
// slave:  the surrounding system, meaning the motion controller and the converter.
interface a2d_intf_if;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] A2D_res;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;

    modport master (
        input  strt_cnv, chnnl, MISO,
        output cnv_cmplt, A2D_res, SS_n, SCLK, MOSI
    );

    modport slave (
        output strt_cnv, chnnl, MISO,
        input  cnv_cmplt, A2D_res, SS_n, SCLK, MOSI
    );
endinterface

// File: rtl/a2d_intf.sv
// SPI master front end for the 8-channel A2D converter.
// One conversion is two 16-bit transactions that both carry the same channel command:
// - the first transaction selects the channel;
// - the second transaction returns that channel's 12-bit result.
// SCLK is div[4] of a 5-bit divider (clk/32). The divider idles at 5'b11111, so SCLK
// rests high.
module a2d_intf #(
    parameter int GAP_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    a2d_intf_if.master bus
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, XFER1, GAP, XFER2} state_t;

    state_t        state;
    state_t        nxt_state;
    logic [15:0]   shft;
    logic [4:0]    div;
    logic [4:0]    bit_cnt;
    logic [GW-1:0] gap_cnt;
    logic          MISO_smpl;
    logic [2:0]    chnnl_q;
    logic          ss_n_q;
    logic          cnv_cmplt_q;
    logic [11:0]   a2d_res_q;
    logic          accept;
    logic          xfer_end;
    logic          gap_end;
    logic          in_xfer;
    logic          xfer_last;
    logic          gap_last;

    assign in_xfer   = (state == XFER1) || (state == XFER2);
    assign xfer_last = (bit_cnt == 5'd16) && (div == 5'b11110);
    assign gap_last  = (gap_cnt == GW'(GAP_CYCLES - 1));

    assign bus.SS_n      = ss_n_q;
    assign bus.SCLK      = div[4];
    assign bus.MOSI      = shft[15];
    assign bus.cnv_cmplt = cnv_cmplt_q;
    assign bus.A2D_res   = a2d_res_q;

    // State register; reset abandons any conversion in flight
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt_state;
    end

    // Next-state decode plus the one-cycle strobes that steer the datapath
    always_comb begin
        nxt_state = state;
        accept    = 1'b0;
        xfer_end  = 1'b0;
        gap_end   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.strt_cnv) begin
                    accept    = 1'b1;
                    nxt_state = XFER1;
                end
            end
            XFER1: begin
                if (xfer_last) begin
                    xfer_end  = 1'b1;
                    nxt_state = GAP;
                end
            end
            GAP: begin
                if (gap_last) begin
                    gap_end   = 1'b1;
                    nxt_state = XFER2;
                end
            end
            XFER2: begin
                if (xfer_last) begin
                    xfer_end  = 1'b1;
                    nxt_state = IDLE;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    // SPI datapath: divider, MISO sampling, shifting, gap timing, and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            shft        <= 16'h0000;
            div         <= 5'b11111;
            bit_cnt     <= 5'd0;
            gap_cnt     <= '0;
            MISO_smpl   <= 1'b0;
            chnnl_q     <= 3'd0;
            ss_n_q      <= 1'b1;
            cnv_cmplt_q <= 1'b0;
            a2d_res_q   <= 12'h000;
        end else if (accept) begin
            chnnl_q     <= bus.chnnl;
            shft        <= {2'b00, bus.chnnl, 11'h000};
            ss_n_q      <= 1'b0;
            div         <= 5'b10111;
            bit_cnt     <= 5'd0;
            cnv_cmplt_q <= 1'b0;
        end else if (xfer_end) begin
            ss_n_q <= 1'b1;
            div    <= 5'b11111;
            if (state == XFER1) begin
                shft    <= {2'b00, chnnl_q, 11'h000};
                gap_cnt <= '0;
            end else begin
                a2d_res_q   <= shft[11:0];
                cnv_cmplt_q <= 1'b1;
            end
        end else if (gap_end) begin
            ss_n_q  <= 1'b0;
            div     <= 5'b10111;
            bit_cnt <= 5'd0;
        end else if (in_xfer) begin
            div <= div + 5'd1;
            if (div == 5'b01111) begin
                MISO_smpl <= bus.MISO;
            end
            if ((div == 5'b10000) && (bit_cnt != 5'd16)) begin
                shft    <= {shft[14:0], MISO_smpl};
                bit_cnt <= bit_cnt + 5'd1;
            end
        end else if (state == GAP) begin
            gap_cnt <= gap_cnt + GW'(1);
        end
    end

endmodule

// File: doc/a2d_intf.md
# a2d_intf

SPI-master front end for the 8-channel A2D converter. It is the responder to the motion block's conversion requests: it accepts `strt_cnv` and `chnnl`, runs two 16-bit SPI transactions to the converter, and returns a 12-bit result with a level `cnv_cmplt`. It sits between the motion controller and the off-chip A2D pins.

## Interface
- `GAP_CYCLES`, default 32: number of clk cycles `SS_n` is held high between the two transactions of one conversion.
- `clk` input 1: system clock, all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `strt_cnv` input 1: single-cycle request to start a conversion; sampled only in IDLE.
- `chnnl` input 3: channel to convert; captured on the accepted `strt_cnv`.
- `cnv_cmplt` output 1: level, set when `A2D_res` is valid; cleared on the next accepted `strt_cnv`.
- `A2D_res` output 12: unsigned conversion result, held until the next completed conversion.
- `SS_n` output 1: active-low converter select.
- `SCLK` output 1: SPI clock at clk/32, idles high (CPOL=1, CPHA=1).
- `MOSI` output 1: serial command out, equal to `shft[15]`.
- `MISO` input 1: serial data from the converter.

## Operation
- Datapath:
  - `shft` is a 16-bit shift register; `MOSI = shft[15]`.
  - `div` is a 5-bit free-running counter while a transaction is active; `SCLK = div[4]`.
  - `bit_cnt` counts up to 16 shifts.
  - `gap_cnt` counts `GAP_CYCLES`.
  - `MISO_smpl` is a 1-bit sample flop.
- Command word: `{2'b00, chnnl_q, 11'h000}`. Both transactions send the same word.
  - The first transaction selects the channel.
  - The second transaction returns that channel's conversion.
- FSM states: IDLE, XFER1, GAP, XFER2.
  - IDLE, on `strt_cnv`:
    - latch `chnnl_q`, load `shft` with the command word;
    - `SS_n<=0`, `div<=5'b10111`, `bit_cnt<=0`, `cnv_cmplt<=0`;
    - go to XFER1.
  - IDLE without `strt_cnv`: hold all outputs.
  - XFER1 and XFER2 (identical):
    - `div` increments every clk.
    - On the clk edge where `div` goes 01111→10000 (SCLK rise), `MISO_smpl<=MISO`.
    - On the next edge (`div`==10000), `shft<={shft[14:0],MISO_smpl}` and `bit_cnt++`.
    - Once `bit_cnt`==16 and `div` reaches 11110, on the next edge `SS_n<=1` and `div` freezes at 11111, so SCLK stays high.
  - XFER1 end: reload `shft` with the command word, `gap_cnt<=0`, go to GAP.
  - GAP: `SS_n`=1, SCLK=1. After `GAP_CYCLES` clks: `SS_n<=0`, `div<=5'b10111`, `bit_cnt<=0`, go to XFER2.
  - XFER2 end, on the same edge `SS_n` rises: `A2D_res<=shft[11:0]`, `cnv_cmplt<=1`, go to IDLE.
- `strt_cnv` outside IDLE is ignored and does not queue.
- `chnnl` changes after acceptance have no effect.
- Reset (any state, including mid-transaction), on the next clk edge:
  - state=IDLE, `SS_n`=1;
  - `div`=11111, so `SCLK`=1;
  - `shft`=0, so `MOSI`=0;
  - `cnv_cmplt`=0, `A2D_res`=0.
  - The partial conversion is discarded.
- `rst` has priority over `strt_cnv` in the same cycle.

## Timing
- Edge 0 is the edge on which `strt_cnv` is accepted. Defaults assumed.
- SPI clock edges within XFER1:
  - the first SCLK fall is at edge 9;
  - SCLK rise n (n=0..15) is at edge 25+32n;
  - the shift for rise n is at edge 26+32n.
- XFER1 ends at edge 520 (`SS_n` low for 520 clks, 16 falls and 16 rises).
- GAP occupies edges 520–552; XFER2 starts with `SS_n` low at edge 552.
- At edge 1072: `SS_n`=1, `cnv_cmplt`=1, `A2D_res` valid. Total latency is 1072 clks.
- MOSI changes exactly one clk after an SCLK rise. It is stable for 31 clks around each rising edge.
- A new `strt_cnv` is accepted at the earliest on edge 1073. `cnv_cmplt` drops on that same edge.

## Test plan
- Reset, then idle for 100 clks: `SS_n`=1, `SCLK`=1, `MOSI`=0, `cnv_cmplt`=0, `A2D_res`=0 throughout.
- `strt_cnv` with `chnnl`=3'b101, against a SPI slave model that returns 16'h0A5C on the second transaction:
  - MOSI word captured on SCLK rises is 16'h2800 in both transactions;
  - `cnv_cmplt` rises at edge 1072 with `A2D_res`=12'hA5C;
  - exactly 16 SCLK rises occur per transaction.
- Slave returns 16'hFFFF then 16'h0FFF: `A2D_res`=12'hFFF. Next conversion returning 16'h0000: `A2D_res`=12'h000. `cnv_cmplt` clears on the second `strt_cnv` and re-sets 1072 clks later.
- `strt_cnv` pulsed at edges 100 and 600 of a running conversion, with `chnnl` changed to 3'b010: both are ignored, XFER2 still sends 16'h2800, and completion is still at edge 1072.
- `rst` asserted at edge 300 (mid XFER1): next edge `SS_n`=1, `SCLK`=1, IDLE. A following `strt_cnv` completes normally after 1072 clks with the correct result.
- `GAP_CYCLES`=4 build: completion at edge 520+4+520=1044; `SS_n` high for exactly 4 clks between transactions.
